// File: rtl/monty_word_red_iter.sv
// Iterative Montgomery word reduction for moduli of the form q = qH*2^W + 1.
// Each operation applies N_STEP steps of acc <- (acc + m*q) / 2^W with
// m = -acc mod 2^W, then optionally subtracts q once so the result is < q.
// Handshaked on both sides; every output is driven straight from a flop.
module monty_word_red_iter #(
    parameter int  Q_LEN     = 64,
    parameter int  W         = 38,
    parameter int  N_STEP    = (Q_LEN + W - 1) / W,
    parameter int  MUL_PIPE  = 1,
    parameter int  FINAL_SUB = 1,
    localparam int K         = 2 * Q_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [Q_LEN-W-1:0] qH,
    input  logic [K-1:0]       C,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Q_LEN:0]     T,
    output logic [Q_LEN-W-1:0] qH_d
);

    localparam int QH_W   = Q_LEN - W;
    localparam int STEP_W = (N_STEP > 1) ? $clog2(N_STEP) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEP - 1);

    typedef enum logic [1:0] {IDLE, RED, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [K-1:0]      acc_q, acc_d;
    logic [QH_W-1:0]   qh_lat_q, qh_lat_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              sub_q, sub_d;
    logic [Q_LEN-1:0]  prod_q, prod_d;
    logic [Q_LEN:0]    t_q, t_d;
    logic [QH_W-1:0]   qh_out_q, qh_out_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [W-1:0]      lo;
    logic [W-1:0]      m;
    logic              cy;
    logic [Q_LEN-1:0]  prod_now;
    logic [Q_LEN-1:0]  prod_use;
    logic [K-1:0]      acc_step;
    logic [K-1:0]      q_full;

    // One reduction step: m cancels the low word, so (lo + m) is either 0 or exactly 2^W (carry cy).
    always_comb begin
        lo       = acc_q[W-1:0];
        m        = ~lo + W'(1);
        cy       = |lo;
        prod_now = Q_LEN'(m) * Q_LEN'(qh_lat_q);
        prod_use = (MUL_PIPE != 0) ? prod_q : prod_now;
        acc_step = (acc_q >> W) + K'(prod_use) + K'(cy);
        q_full   = K'({qh_lat_q, {W{1'b0}}}) + K'(1);
    end

    // Operation sequencing: accept in IDLE, step in RED, finalise in FIX, hold in DONE until taken.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        qh_lat_d    = qh_lat_q;
        step_d      = step_q;
        sub_d       = sub_q;
        prod_d      = prod_q;
        t_d         = t_q;
        qh_out_d    = qh_out_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d      = C;
                    qh_lat_d   = qH;
                    step_d     = '0;
                    sub_d      = 1'b0;
                    state_d    = RED;
                    in_ready_d = 1'b0;
                end
            end
            RED: begin
                if ((MUL_PIPE != 0) && !sub_q) begin
                    prod_d = prod_now;
                    sub_d  = 1'b1;
                end else begin
                    acc_d = acc_step;
                    sub_d = 1'b0;
                    if (step_q == LAST_STEP) begin
                        step_d  = '0;
                        state_d = FIX;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            FIX: begin
                if ((FINAL_SUB != 0) && (acc_q >= q_full)) begin
                    t_d = (Q_LEN+1)'(acc_q - q_full);
                end else begin
                    t_d = acc_q[Q_LEN:0];
                end
                qh_out_d    = qh_lat_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            qh_lat_q    <= '0;
            step_q      <= '0;
            sub_q       <= 1'b0;
            prod_q      <= '0;
            t_q         <= '0;
            qh_out_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            qh_lat_q    <= qh_lat_d;
            step_q      <= step_d;
            sub_q       <= sub_d;
            prod_q      <= prod_d;
            t_q         <= t_d;
            qh_out_q    <= qh_out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign T         = t_q;
    assign qH_d      = qh_out_q;

endmodule
